// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - state_t   : FSM state encoding (S_IDLE, S_WAIT, S_RESP)
//   - ERR_DATA  : read data returned for an out-of-range access
//   - LAT_MIN/LAT_MAX : legal range of the wait-state count
//   - CNT_W     : width of the wait-state counter (holds LAT_MAX-1)
//   - wait_init : preload value of the wait counter for a given latency
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    localparam int unsigned LAT_MIN = 32'd1;
    localparam int unsigned LAT_MAX = 32'd15;
    localparam int unsigned CNT_W   = 32'd4;

    // The counter is loaded on accept and commit happens when it reaches zero,
    // so it starts at LATENCY-1. Out-of-range latencies are clamped so the
    // preload always fits in CNT_W bits.
    function automatic logic [CNT_W-1:0] wait_init(input int unsigned latency);
        int unsigned lat_v;
        if (latency < LAT_MIN) begin
            lat_v = LAT_MIN;
        end else if (latency > LAT_MAX) begin
            lat_v = LAT_MAX;
        end else begin
            lat_v = latency;
        end
        return CNT_W'(lat_v - 32'd1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word storage with a registered read.
// No reset on purpose, so this can be swapped for a vendor RAM macro.
// Ports:
//   clk    in  clock
//   we     in  write enable (write wdata to addr on the rising edge)
//   addr   in  word index (IDX_W bits)
//   wdata  in  write data
//   rdata  out registered read of addr (old data on a same-cycle write)
module dmem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage write port and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata_r <= mem_r[addr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: target end of the MEM-stage load/store interface.
// Accepts one request at a time, waits LATENCY cycles, then commits a store
// or returns load data with a one-cycle response strobe. busy stalls the
// pipeline; flush drops a request that has not committed yet.
// Optional feature: define DMEM_RANGE_CHK_EN to flag addresses >= DEPTH
// (no array access, rsp_err=1, rsp_rdata=ERR_DATA). Without it, addresses
// wrap modulo DEPTH and rsp_err stays 0.
// Ports:
//   clk        in  clock
//   rst        in  asynchronous active-low reset
//   req_valid  in  request present
//   req_write  in  1 = store, 0 = load
//   req_addr   in  word address
//   req_wdata  in  store data
//   req_ready  out responder can accept this cycle
//   flush      in  abort any uncommitted request
//   busy       out request in flight, pipeline must stall
//   rsp_valid  out single-cycle response strobe
//   rsp_rdata  out load data, or echo of the stored word
//   rsp_err    out out-of-range access (range check build only)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    input  logic              flush,
    output logic              busy,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned      IDX_W    = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_INIT = wait_init(LATENCY);

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              req_ready_r;
    logic              busy_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    logic              in_range_s;
    logic              commit_s;
    logic              arr_we_s;
    logic [IDX_W-1:0]  arr_addr_s;
    logic [DATA_W-1:0] arr_rdata_s;

`ifdef DMEM_RANGE_CHK_EN
    // Range check on the full latched address
    always_comb begin
        if (32'(addr_r) < 32'(DEPTH)) begin
            in_range_s = 1'b1;
        end else begin
            in_range_s = 1'b0;
        end
    end
`else
    // Without the range check every address wraps into the array
    logic unused_addr_s;
    assign unused_addr_s = ^addr_r;

    always_comb begin
        in_range_s = 1'b1;
    end
`endif

    // Commit strobe and array write/address control.
    // While idle the array reads the incoming address so that its registered
    // read data is already valid when a LATENCY=1 request commits.
    always_comb begin
        commit_s = (state_r == S_WAIT) && !flush && (cnt_r == CNT_W'(0));
        arr_we_s = commit_s && write_r && in_range_s;
        if (state_r == S_IDLE) begin
            arr_addr_s = req_addr[IDX_W-1:0];
        end else begin
            arr_addr_s = addr_r[IDX_W-1:0];
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (arr_we_s),
        .addr   (arr_addr_s),
        .wdata  (wdata_r),
        .rdata  (arr_rdata_s)
    );

    // Request FSM with wait counter, request latches and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= CNT_W'(0);
            write_r     <= 1'b0;
            addr_r      <= ADDR_W'(0);
            wdata_r     <= DATA_W'(0);
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= DATA_W'(0);
        end else begin
            case (state_r)
                S_IDLE: begin
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    if (req_valid && !flush) begin
                        write_r     <= req_write;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        cnt_r       <= CNT_INIT;
                        state_r     <= S_WAIT;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        // A flushed request is simply dropped
                        state_r     <= S_IDLE;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state_r     <= S_IDLE;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else if (cnt_r != CNT_W'(0)) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        state_r     <= S_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= !in_range_s;
                        if (!in_range_s) begin
                            rsp_rdata_r <= DATA_W'(ERR_DATA);
                        end else if (write_r) begin
                            rsp_rdata_r <= wdata_r;
                        end else begin
                            rsp_rdata_r <= arr_rdata_s;
                        end
                    end
                end
                S_RESP: begin
                    // Already committed, so flush has no effect here
                    state_r     <= S_IDLE;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= S_IDLE;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with LATENCY=2 (sel=0)
// and one with LATENCY=1 (sel=1), sharing stimulus; request inputs are gated
// to the selected instance and its outputs are muxed onto the *_o signals.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    int          sel;

    logic        va, vb, fa, fb;
    logic        ready_a, busy_a, rv_a, err_a;
    logic        ready_b, busy_b, rv_b, err_b;
    logic [31:0] rd_a, rd_b;
    logic        ready_o, busy_o, rv_o, err_o;
    logic [31:0] rd_o;

    int total = 0;
    int bad   = 0;
    int rsp_seen = 0;

    logic [31:0] got_rd;
    logic        got_err;
    int          got_lat;
    int          s0;

    always #5 clk = ~clk;

    assign va = req_valid & (sel == 0);
    assign vb = req_valid & (sel == 1);
    assign fa = flush & (sel == 0);
    assign fb = flush & (sel == 1);

    assign ready_o = (sel == 0) ? ready_a : ready_b;
    assign busy_o  = (sel == 0) ? busy_a  : busy_b;
    assign rv_o    = (sel == 0) ? rv_a    : rv_b;
    assign err_o   = (sel == 0) ? err_a   : err_b;
    assign rd_o    = (sel == 0) ? rd_a    : rd_b;

    dmem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .req_valid(va), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_a),
        .flush(fa), .busy(busy_a), .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a)
    );

    dmem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(vb), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_b),
        .flush(fb), .busy(busy_b), .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b)
    );

    // Count response strobes of the selected instance
    always @(negedge clk) begin
        if (rv_o === 1'b1) rsp_seen = rsp_seen + 1;
    end

    // One full transaction: wait for ready, present for one cycle, wait for rsp_valid.
    // lat = number of rising edges from the accept edge to the one raising rsp_valid.
    task automatic xact(input logic w, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL xact_ready_timeout addr=%0d", a);
        end
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rv_o === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL xact_rsp_timeout addr=%0d", a);
        end
        rd = rd_o;
        err = err_o;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        sel = 0; rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 16'd0; req_wdata = 32'd0; flush = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        total++; if (rv_o !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rv_o); end
        total++; if (rd_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rd_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
        rst = 1'b1;
        @(negedge clk);
        xact(1'b1, 16'd5, 32'h0BAD_0005, got_rd, got_err, got_lat);
        total++; if (got_lat !== 2) begin bad++; $display("FAIL rst_pre_lat got=%0d exp=2", got_lat); end
        // store 0x1234 to addr 5, reset in the middle of WAIT
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd5; req_wdata = 32'h0000_1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
        total++; if (rv_o !== 1'b0) begin bad++; $display("FAIL midrst_rsp_valid got=%b exp=0", rv_o); end
        total++; if (rd_o !== 32'h0) begin bad++; $display("FAIL midrst_rdata got=%h exp=0", rd_o); end
        @(negedge clk);
        rst = 1'b1;
        s0 = rsp_seen;
        repeat (4) @(negedge clk);
        total++; if (rsp_seen !== s0) begin bad++; $display("FAIL midrst_no_rsp got=%0d exp=%0d", rsp_seen, s0); end
        xact(1'b0, 16'd5, 32'h0, got_rd, got_err, got_lat);
        total++; if (got_rd !== 32'h0BAD_0005) begin bad++; $display("FAIL midrst_old_data got=%h exp=0bad0005", got_rd); end
    endtask

    task automatic test_store_load();
        sel = 0;
        xact(1'b1, 16'd3, 32'hCAFE_F00D, got_rd, got_err, got_lat);
        total++; if (got_lat !== 2) begin bad++; $display("FAIL st_lat got=%0d exp=2", got_lat); end
        total++; if (got_rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL st_echo got=%h exp=cafef00d", got_rd); end
        total++; if (got_err !== 1'b0) begin bad++; $display("FAIL st_err got=%b exp=0", got_err); end
        xact(1'b0, 16'd3, 32'h0, got_rd, got_err, got_lat);
        total++; if (got_lat !== 2) begin bad++; $display("FAIL ld_lat got=%0d exp=2", got_lat); end
        total++; if (got_rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL ld_data got=%h exp=cafef00d", got_rd); end
        total++; if (rd_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL ld_hold got=%h exp=cafef00d", rd_o); end
        total++; if (rv_o !== 1'b0) begin bad++; $display("FAIL ld_strobe_len got=%b exp=0", rv_o); end
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        sel = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'd3; req_wdata = 32'h0;
        for (int i = 0; i < 12; i++) begin
            exp_rdy = ((i % 4) == 0);
            total++; if (ready_o !== exp_rdy) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, ready_o, exp_rdy); end
            total++; if (busy_o !== !exp_rdy) begin bad++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", i, busy_o, !exp_rdy); end
            total++; if (rv_o !== ((i % 4) == 3)) begin bad++; $display("FAIL b2b_rsp[%0d] got=%b exp=%b", i, rv_o, ((i % 4) == 3)); end
            if (i == 11) req_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        sel = 0;
        xact(1'b1, 16'd7, 32'h7777_0007, got_rd, got_err, got_lat);
        // flush in the first WAIT cycle
        s0 = rsp_seen;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd7; req_wdata = 32'h0000_5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL fl1_ready got=%b exp=1", ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL fl1_busy got=%b exp=0", busy_o); end
        repeat (4) @(negedge clk);
        total++; if (rsp_seen !== s0) begin bad++; $display("FAIL fl1_no_rsp got=%0d exp=%0d", rsp_seen, s0); end
        // flush in the last WAIT cycle
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd7; req_wdata = 32'h0000_9999;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (rsp_seen !== s0) begin bad++; $display("FAIL fl2_no_rsp got=%0d exp=%0d", rsp_seen, s0); end
        // flush together with a request in IDLE
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_write = 1'b1; req_addr = 16'd7; req_wdata = 32'h0000_6666;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL fl3_busy got=%b exp=0", busy_o); end
        repeat (4) @(negedge clk);
        total++; if (rsp_seen !== s0) begin bad++; $display("FAIL fl3_no_rsp got=%0d exp=%0d", rsp_seen, s0); end
        xact(1'b0, 16'd7, 32'h0, got_rd, got_err, got_lat);
        total++; if (got_rd !== 32'h7777_0007) begin bad++; $display("FAIL fl_prior got=%h exp=77770007", got_rd); end
        // flush during RESP is ignored
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd8; req_wdata = 32'h8888_0008;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        total++; if (rv_o !== 1'b1) begin bad++; $display("FAIL flresp_valid got=%b exp=1", rv_o); end
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL flresp_ready got=%b exp=1", ready_o); end
        xact(1'b0, 16'd8, 32'h0, got_rd, got_err, got_lat);
        total++; if (got_rd !== 32'h8888_0008) begin bad++; $display("FAIL flresp_commit got=%h exp=88880008", got_rd); end
    endtask

    task automatic test_range();
        sel = 0;
        xact(1'b1, 16'd4, 32'h4444_0004, got_rd, got_err, got_lat);
`ifdef DMEM_RANGE_CHK_EN
        xact(1'b0, 16'd1024, 32'h0, got_rd, got_err, got_lat);
        total++; if (got_err !== 1'b1) begin bad++; $display("FAIL rng_ld_err got=%b exp=1", got_err); end
        total++; if (got_rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rng_ld_data got=%h exp=deadbeef", got_rd); end
        xact(1'b1, 16'd1028, 32'hABCD_0004, got_rd, got_err, got_lat);
        total++; if (got_err !== 1'b1) begin bad++; $display("FAIL rng_st_err got=%b exp=1", got_err); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rng_err_idle got=%b exp=0", err_o); end
        xact(1'b0, 16'd4, 32'h0, got_rd, got_err, got_lat);
        total++; if (got_rd !== 32'h4444_0004) begin bad++; $display("FAIL rng_nowrite got=%h exp=44440004", got_rd); end
        total++; if (got_err !== 1'b0) begin bad++; $display("FAIL rng_inrange_err got=%b exp=0", got_err); end
`else
        xact(1'b1, 16'd1028, 32'hABCD_0004, got_rd, got_err, got_lat);
        total++; if (got_err !== 1'b0) begin bad++; $display("FAIL wrap_st_err got=%b exp=0", got_err); end
        total++; if (got_rd !== 32'hABCD_0004) begin bad++; $display("FAIL wrap_st_echo got=%h exp=abcd0004", got_rd); end
        xact(1'b0, 16'd4, 32'h0, got_rd, got_err, got_lat);
        total++; if (got_rd !== 32'hABCD_0004) begin bad++; $display("FAIL wrap_ld got=%h exp=abcd0004", got_rd); end
        total++; if (got_err !== 1'b0) begin bad++; $display("FAIL wrap_ld_err got=%b exp=0", got_err); end
`endif
    endtask

    task automatic test_latency1();
        sel = 1;
        xact(1'b1, 16'd0, 32'h0000_A0A0, got_rd, got_err, got_lat);
        total++; if (got_lat !== 1) begin bad++; $display("FAIL l1_st0_lat got=%0d exp=1", got_lat); end
        xact(1'b1, 16'd1023, 32'hFFFF_1023, got_rd, got_err, got_lat);
        total++; if (got_lat !== 1) begin bad++; $display("FAIL l1_sttop_lat got=%0d exp=1", got_lat); end
        xact(1'b0, 16'd0, 32'h0, got_rd, got_err, got_lat);
        total++; if (got_rd !== 32'h0000_A0A0) begin bad++; $display("FAIL l1_ld0 got=%h exp=0000a0a0", got_rd); end
        total++; if (got_lat !== 1) begin bad++; $display("FAIL l1_ld0_lat got=%0d exp=1", got_lat); end
        xact(1'b0, 16'd1023, 32'h0, got_rd, got_err, got_lat);
        total++; if (got_rd !== 32'hFFFF_1023) begin bad++; $display("FAIL l1_ldtop got=%h exp=ffff1023", got_rd); end
        total++; if (got_lat !== 1) begin bad++; $display("FAIL l1_ldtop_lat got=%0d exp=1", got_lat); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_flush();
        test_range();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
